// File: rtl/prg_ram_writer.sv
// rtl/prg_ram_writer.sv - PRG image loader that writes payload bytes into C64 RAM
//
// Consumes the SD-card loader ioctl byte stream while load_prg is high. The
// first two bytes form the little-endian load address; every further byte is
// written to RAM at start+N through a ram_we/ram_ack handshake. ioctl_wait
// holds the loader off while a write is outstanding.
//
// Optional feature macro: PRG_PTR_UPDATE_EN
//   defined   : after the download ends, the end address is written to
//               $2D-$32 (only when start == BASIC_START) and to $AE/$AF
//   undefined : no pointer writes; the end of the download goes straight to DONE
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   ioctl_download     high for the whole transfer
//   load_prg           high when the transfer is a PRG image
//   ioctl_addr         byte index within the file (not needed, bytes arrive in order)
//   ioctl_data/wr      byte and its one-cycle strobe
//   ioctl_wait         loader must hold off the next strobe
//   ram_addr/dout/we   RAM write request, held until ram_ack
//   ram_ack            one-cycle write-complete pulse
//   prg_busy           high from the start of a load until DONE
//   prg_done           one-cycle pulse at the end of every load
//   prg_err            sticky error flag, cleared when the next load starts
//   prg_start_addr     load address from the header
//   prg_end_addr       one past the last byte written
module prg_ram_writer #(
   parameter logic [15:0] BASIC_START = 16'h0801,
   parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        load_prg,
   input  logic [22:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   input  logic        ioctl_wr,
   output logic        ioctl_wait,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_dout,
   output logic        ram_we,
   input  logic        ram_ack,
   output logic        prg_busy,
   output logic        prg_done,
   output logic        prg_err,
   output logic [15:0] prg_start_addr,
   output logic [15:0] prg_end_addr
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HDR_LO  = 3'd1,
      S_HDR_HI  = 3'd2,
      S_DATA    = 3'd3,
      S_WR_WAIT = 3'd4,
`ifdef PRG_PTR_UPDATE_EN
      S_PTR     = 3'd5,
`endif
      S_DONE    = 3'd6
   } state_t;

`ifdef PRG_PTR_UPDATE_EN
   localparam state_t S_END = S_PTR;
`else
   localparam state_t S_END = S_DONE;
`endif

   state_t      state_q, state_d;
   logic        dl_q, dl_d;
   logic [15:0] start_q, start_d;
   logic [15:0] end_q, end_d;
   logic [16:0] n_q, n_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  dout_q, dout_d;
   logic        we_q, we_d;
   logic        wait_q, wait_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic [7:0]  to_cnt_q, to_cnt_d;
`ifdef PRG_PTR_UPDATE_EN
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  ptr_lo;
`endif

   logic        wr_ok;
   logic        dl_rise;
   logic [16:0] sum;
   logic        overflow;
   logic        ack_expired;
   logic        unused_addr;

   assign wr_ok       = ioctl_wr & load_prg;
   assign dl_rise     = ioctl_download & ~dl_q;
   // 17-bit sum: bit 16 set means the next byte would land beyond $FFFF.
   // N stops counting once that happens, so the condition stays set and all
   // later bytes are discarded too.
   assign sum         = {1'b0, start_q} + n_q;
   assign overflow    = sum[16];
   assign ack_expired = (to_cnt_q == ACK_TIMEOUT - 8'd1);
   assign unused_addr = ^ioctl_addr;

`ifdef PRG_PTR_UPDATE_EN
   // idx 0..5 -> $2D..$32, idx 6..7 -> $AE/$AF; even idx carries the low byte
   assign ptr_lo = (idx_q < 3'd6) ? (8'h2D + {5'd0, idx_q}) : (8'hA8 + {5'd0, idx_q});
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         dl_q     <= 1'b0;
         start_q  <= 16'h0000;
         end_q    <= 16'h0000;
         n_q      <= 17'd0;
         addr_q   <= 16'h0000;
         dout_q   <= 8'h00;
         we_q     <= 1'b0;
         wait_q   <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         to_cnt_q <= 8'd0;
`ifdef PRG_PTR_UPDATE_EN
         idx_q    <= 3'd0;
`endif
      end else begin
         state_q  <= state_d;
         dl_q     <= dl_d;
         start_q  <= start_d;
         end_q    <= end_d;
         n_q      <= n_d;
         addr_q   <= addr_d;
         dout_q   <= dout_d;
         we_q     <= we_d;
         wait_q   <= wait_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         to_cnt_q <= to_cnt_d;
`ifdef PRG_PTR_UPDATE_EN
         idx_q    <= idx_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (dl_rise && load_prg) state_d = S_HDR_LO;
         S_HDR_LO:  if (!ioctl_download) state_d = S_DONE;
                    else if (wr_ok) state_d = S_HDR_HI;
         S_HDR_HI:  if (!ioctl_download) state_d = S_DONE;
                    else if (wr_ok) state_d = S_DATA;
         // A strobe coinciding with the end of download is taken first; the
         // end is then seen on the return from WR_WAIT.
         S_DATA:    if (wr_ok && !overflow) state_d = S_WR_WAIT;
                    else if (!ioctl_download) state_d = S_END;
         S_WR_WAIT: if (ram_ack) state_d = S_DATA;
                    else if (ack_expired) state_d = S_DONE;
`ifdef PRG_PTR_UPDATE_EN
         S_PTR:     if (we_q) begin
                       if (ram_ack) begin
                          if (idx_q == 3'd7) state_d = S_DONE;
                       end else if (ack_expired) begin
                          state_d = S_DONE;
                       end
                    end
`endif
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dl_d     = ioctl_download;
      start_d  = start_q;
      end_d    = end_q;
      n_d      = n_q;
      addr_d   = addr_q;
      dout_d   = dout_q;
      we_d     = we_q;
      wait_d   = wait_q;
      busy_d   = busy_q;
      err_d    = err_q;
      to_cnt_d = to_cnt_q;
`ifdef PRG_PTR_UPDATE_EN
      idx_d    = idx_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (dl_rise && load_prg) begin
               err_d  = 1'b0;
               busy_d = 1'b1;
            end
         end
         S_HDR_LO: begin
            if (!ioctl_download) err_d = 1'b1;
            else if (wr_ok) start_d[7:0] = ioctl_data;
         end
         S_HDR_HI: begin
            if (!ioctl_download) begin
               err_d = 1'b1;
            end else if (wr_ok) begin
               start_d[15:8] = ioctl_data;
               n_d           = 17'd0;
            end
         end
         S_DATA: begin
            if (wr_ok && !overflow) begin
               addr_d   = sum[15:0];
               dout_d   = ioctl_data;
               we_d     = 1'b1;
               wait_d   = 1'b1;
               to_cnt_d = 8'd0;
            end else begin
               if (wr_ok) err_d = 1'b1;
               if (!ioctl_download) begin
                  end_d = sum[15:0];
`ifdef PRG_PTR_UPDATE_EN
                  idx_d = (start_q == BASIC_START) ? 3'd0 : 3'd6;
`endif
               end
            end
         end
         S_WR_WAIT: begin
            if (wr_ok) err_d = 1'b1;
            if (ram_ack) begin
               we_d   = 1'b0;
               wait_d = 1'b0;
               n_d    = n_q + 17'd1;
            end else if (ack_expired) begin
               we_d   = 1'b0;
               wait_d = 1'b0;
               err_d  = 1'b1;
               end_d  = sum[15:0];
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
            end
         end
`ifdef PRG_PTR_UPDATE_EN
         // ram_we is dropped for one cycle between pointer writes so every
         // request is a distinct rising edge for the RAM arbiter.
         S_PTR: begin
            if (!we_q) begin
               addr_d   = {8'h00, ptr_lo};
               dout_d   = idx_q[0] ? end_q[15:8] : end_q[7:0];
               we_d     = 1'b1;
               to_cnt_d = 8'd0;
            end else if (ram_ack) begin
               we_d = 1'b0;
               if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
            end else if (ack_expired) begin
               we_d  = 1'b0;
               err_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
            end
         end
`endif
         S_DONE: busy_d = 1'b0;
         default: ;
      endcase
   end

   assign ioctl_wait     = wait_q;
   assign ram_addr       = addr_q;
   assign ram_dout       = dout_q;
   assign ram_we         = we_q;
   assign prg_busy       = busy_q;
   assign prg_done       = (state_q == S_DONE);
   assign prg_err        = err_q;
   assign prg_start_addr = start_q;
   assign prg_end_addr   = end_q;

endmodule

// File: tb/tb_prg_ram_writer.sv
// tb/tb_prg_ram_writer.sv - randomized self-checking bench for prg_ram_writer
module tb_prg_ram_writer;

   logic        clk;
   logic        reset;
   logic        ioctl_download;
   logic        load_prg;
   logic [22:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic        ioctl_wr;
   logic        ioctl_wait;
   logic [15:0] ram_addr;
   logic [7:0]  ram_dout;
   logic        ram_we;
   logic        ram_ack;
   logic        prg_busy;
   logic        prg_done;
   logic        prg_err;
   logic [15:0] prg_start_addr;
   logic [15:0] prg_end_addr;

   prg_ram_writer dut (
      .clk            (clk),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .load_prg       (load_prg),
      .ioctl_addr     (ioctl_addr),
      .ioctl_data     (ioctl_data),
      .ioctl_wr       (ioctl_wr),
      .ioctl_wait     (ioctl_wait),
      .ram_addr       (ram_addr),
      .ram_dout       (ram_dout),
      .ram_we         (ram_we),
      .ram_ack        (ram_ack),
      .prg_busy       (prg_busy),
      .prg_done       (prg_done),
      .prg_err        (prg_err),
      .prg_start_addr (prg_start_addr),
      .prg_end_addr   (prg_end_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          ack_dly = -1;      // -1: random 0..3 cycles
   bit          noack = 1'b0;
   int          done_total = 0;
   int          we_run_last = 0;
   logic [23:0] wlog[$];           // completed writes {addr, data}
   logic [7:0]  file_q[$];
   logic [23:0] exp_w[$];
   logic        exp_err;
   logic [15:0] exp_start;
   logic [15:0] exp_end;
   logic        busy_mid;
   bit          hung;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // RAM side: acknowledge each request after a few cycles, logging it
   initial begin
      int d;
      ram_ack = 1'b0;
      forever begin
         tick();
         if (ram_we && !noack && !reset) begin
            d = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
            repeat (d) tick();
            ram_ack = 1'b1;
            wlog.push_back({ram_addr, ram_dout});
            tick();
            ram_ack = 1'b0;
         end
      end
   end

   initial begin
      int run;
      run = 0;
      forever begin
         tick();
         if (prg_done) done_total++;
         if (ram_we) run++;
         else begin
            if (run != 0) we_run_last = run;
            run = 0;
         end
      end
   end

   // Expected outcome from the file contents alone
   task automatic build_expect();
      int n, start, cnt;
      n = file_q.size();
      exp_w.delete();
      exp_err = 1'b0;
      exp_start = 16'h0;
      exp_end = 16'h0;
      if (n < 2) begin
         exp_err = 1'b1;
         return;
      end
      start = int'(file_q[0]) + 256 * int'(file_q[1]);
      cnt = 0;
      for (int i = 2; i < n; i++) begin
         if (start + cnt <= 65535) begin
            exp_w.push_back({16'(start + cnt), file_q[i]});
            cnt++;
         end else begin
            exp_err = 1'b1;
         end
      end
      exp_start = 16'(start);
      exp_end = 16'((start + cnt) % 65536);
`ifdef PRG_PTR_UPDATE_EN
      if (start == 'h0801) begin
         for (int p = 'h2D; p <= 'h31; p += 2) begin
            exp_w.push_back({16'(p), exp_end[7:0]});
            exp_w.push_back({16'(p + 1), exp_end[15:8]});
         end
      end
      exp_w.push_back({16'h00AE, exp_end[7:0]});
      exp_w.push_back({16'h00AF, exp_end[15:8]});
`endif
   endtask

   task automatic strobe(input int idx, input logic [7:0] b);
      ioctl_addr = 23'(idx);
      ioctl_data = b;
      ioctl_wr = 1'b1;
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic drive_file(input logic lp);
      int guard;
      hung = 1'b0;
      load_prg = lp;
      ioctl_download = 1'b1;
      tick();
      busy_mid = prg_busy;
      for (int i = 0; i < file_q.size(); i++) begin
         strobe(i, file_q[i]);
         guard = 0;
         while (ioctl_wait && guard < 1000) begin
            tick();
            guard++;
         end
         if (guard >= 1000) hung = 1'b1;
         repeat ($urandom_range(0, 2)) tick();
      end
      ioctl_download = 1'b0;
   endtask

   task automatic wait_done(input int base);
      int guard;
      guard = 0;
      while (done_total == base && guard < 3000) begin
         tick();
         guard++;
      end
      if (guard >= 3000) hung = 1'b1;
      repeat (2) tick();
   endtask

   task automatic run_load(input logic lp);
      int base_d, base_w, nw;
      base_d = done_total;
      base_w = wlog.size();
      build_expect();
      drive_file(lp);
      if (lp) wait_done(base_d);
      else repeat (20) tick();
      load_prg = 1'b0;
      check("no_hang", 32'(hung), 32'd0);
      check("busy_mid", 32'(busy_mid), 32'(lp));
      check("busy_end", 32'(prg_busy), 32'd0);
      nw = wlog.size() - base_w;
      if (lp) begin
         check("done_cnt", 32'(done_total - base_d), 32'd1);
         check("err", 32'(prg_err), 32'(exp_err));
         if (file_q.size() >= 2) begin
            check("start", 32'(prg_start_addr), 32'(exp_start));
            check("end", 32'(prg_end_addr), 32'(exp_end));
         end
         check("n_writes", 32'(nw), 32'(exp_w.size()));
         for (int i = 0; i < nw && i < exp_w.size(); i++)
            check("write", 32'(wlog[base_w + i]), 32'(exp_w[i]));
      end else begin
         check("ign_done", 32'(done_total - base_d), 32'd0);
         check("ign_writes", 32'(nw), 32'd0);
      end
      repeat (3) tick();
   endtask

   task automatic set_file(input logic [7:0] a0, input logic [7:0] a1, input int n, input logic [63:0] bytes);
      file_q.delete();
      file_q.push_back(a0);
      file_q.push_back(a1);
      for (int i = 0; i < n; i++) file_q.push_back(bytes[8*i +: 8]);
   endtask

   initial begin
      int n, kind, base_d, base_w;
      logic [15:0] st;
      reset = 1'b1;
      ioctl_download = 1'b0;
      load_prg = 1'b0;
      ioctl_addr = '0;
      ioctl_data = '0;
      ioctl_wr = 1'b0;
      repeat (3) tick();
      check("rst_wait", 32'(ioctl_wait), 32'd0);
      check("rst_we", 32'(ram_we), 32'd0);
      check("rst_addr", 32'(ram_addr), 32'd0);
      check("rst_dout", 32'(ram_dout), 32'd0);
      check("rst_busy", 32'(prg_busy), 32'd0);
      check("rst_done", 32'(prg_done), 32'd0);
      check("rst_err", 32'(prg_err), 32'd0);
      check("rst_start", 32'(prg_start_addr), 32'd0);
      check("rst_end", 32'(prg_end_addr), 32'd0);
      reset = 1'b0;
      repeat (2) tick();

      ack_dly = 2;
      set_file(8'h01, 8'h08, 3, 64'h0000_0000_00CC_BBAA);
      run_load(1'b1);
      set_file(8'h00, 8'hC0, 3, 64'h0000_0000_0033_2211);
      run_load(1'b1);
      ack_dly = -1;
      set_file(8'hFE, 8'hFF, 4, 64'h0000_0000_4433_2211);
      run_load(1'b1);
      file_q.delete();
      file_q.push_back(8'h01);
      run_load(1'b1);

      // RAM never acknowledges: request must be withdrawn after the timeout
      noack = 1'b1;
      base_d = done_total;
      base_w = wlog.size();
      set_file(8'h00, 8'h10, 1, 64'h55);
      drive_file(1'b1);
      wait_done(base_d);
      load_prg = 1'b0;
      check("to_hang", 32'(hung), 32'd0);
      check("to_we_len", 32'(we_run_last), 32'd255);
      check("to_err", 32'(prg_err), 32'd1);
      check("to_done", 32'(done_total - base_d), 32'd1);
      check("to_writes", 32'(wlog.size() - base_w), 32'd0);
      repeat (3) tick();

      // Reset while a write is pending
      load_prg = 1'b1;
      ioctl_download = 1'b1;
      tick();
      strobe(0, 8'h00);
      strobe(1, 8'h20);
      strobe(2, 8'h77);
      check("pre_rst_we", 32'(ram_we), 32'd1);
      reset = 1'b1;
      tick();
      check("mid_rst_we", 32'(ram_we), 32'd0);
      check("mid_rst_wait", 32'(ioctl_wait), 32'd0);
      check("mid_rst_busy", 32'(prg_busy), 32'd0);
      check("mid_rst_start", 32'(prg_start_addr), 32'd0);
      check("mid_rst_addr", 32'(ram_addr), 32'd0);
      reset = 1'b0;
      ioctl_download = 1'b0;
      load_prg = 1'b0;
      noack = 1'b0;
      repeat (3) tick();
      set_file(8'h01, 8'h08, 3, 64'h0000_0000_00CC_BBAA);
      run_load(1'b1);

      set_file(8'h00, 8'h30, 2, 64'h0000_0000_0000_1234);
      run_load(1'b0);

      for (int t = 0; t < 30; t++) begin
         n = $urandom_range(0, 14);
         kind = $urandom_range(0, 3);
         st = (kind == 0) ? 16'h0801 : (kind == 1) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
         file_q.delete();
         for (int i = 0; i < n; i++) begin
            if (i == 0) file_q.push_back(st[7:0]);
            else if (i == 1) file_q.push_back(st[15:8]);
            else file_q.push_back(8'($urandom));
         end
         run_load(($urandom_range(0, 5) != 0) ? 1'b1 : 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
